// File: rtl/freq_sel_ctrl.sv
// Run-time rate controller: owns the 3-bit divisor select, runs the period counter,
// and emits a divided square wave plus a per-period tick. Optional macro FREQ_SEL_WRAP_EN.
module freq_sel_ctrl #(
  parameter logic [2:0]  RESET_SEL = 3'd0,
  parameter int unsigned DIV_W     = 32,
  parameter int unsigned MIN_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  output logic [2:0]       sel_out,
  input  logic [DIV_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE_W     = DIV_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  logic             step_up, step_dn, sel_chg, last;
  logic [DIV_W-1:0] div_clamped;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    busy_d    = busy_q;

    step_up = up & ~down;
    step_dn = down & ~up;

`ifdef FREQ_SEL_WRAP_EN
    if (step_up)      sel_d = sel_q + 3'd1;
    else if (step_dn) sel_d = sel_q - 3'd1;
`else
    if (step_up && sel_q != 3'd7)      sel_d = sel_q + 3'd1;
    else if (step_dn && sel_q != 3'd0) sel_d = sel_q - 3'd1;
`endif
    sel_chg = (sel_d != sel_q);

    div_clamped = (div_in < MIN_DIV_W) ? MIN_DIV_W : div_in;
    last        = (cnt_q == act_div_q - ONE_W);

    case (state_q)
      ST_INIT: begin
        act_div_d = div_clamped;
        cnt_d     = '0;
        clk_out_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_RUN;
      end
      default: begin
        if (en) begin
          tick_d = last;
          cnt_d  = last ? '0 : cnt_q + ONE_W;
          // div_in still reflects the select that was live before this edge's step.
          if (last && busy_q) begin
            act_div_d = div_clamped;
            busy_d    = 1'b0;
          end
          clk_out_d = (cnt_d < (act_div_d >> 1));
        end
      end
    endcase

    // A fresh select always wins over a boundary clear in the same cycle.
    if (sel_chg) busy_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      sel_q     <= RESET_SEL;
      cnt_q     <= '0;
      act_div_q <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
    end
  end

  assign sel_out = sel_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// Self-checking bench for freq_sel_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a period-level reference model.
module tb_freq_sel_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, up = 1'b0, down = 1'b0;
  logic [2:0]  sel_out;
  logic [31:0] div_in;
  logic        clk_out, tick, busy;

  int checks   = 0;
  int failures = 0;

  int dec_tab[8] = '{20, 15, 10, 5, 4, 3, 2, 1};

  assign div_in = 32'(dec_tab[sel_out]);

  always #5 clk = ~clk;

  freq_sel_ctrl #(.RESET_SEL(3'd0), .DIV_W(32), .MIN_DIV(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .down    (down),
    .sel_out (sel_out),
    .div_in  (div_in),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  // Reference model: position within the current period and the period length.
  int m_sel, m_pos, m_per;
  bit m_init, m_busy, m_clk, m_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_pos = 0; m_per = 0;
    m_init = 1'b1; m_busy = 1'b1; m_clk = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit u, input bit d);
    int tgt;
    bit chg;
    tgt = m_sel + int'(u) - int'(d);
`ifdef FREQ_SEL_WRAP_EN
    tgt = (tgt + 8) % 8;
`else
    if (tgt > 7) tgt = 7;
    if (tgt < 0) tgt = 0;
`endif
    chg = (tgt != m_sel);
    if (m_init) begin
      m_per = clamp_div(dec_tab[m_sel]);
      m_pos = 0; m_clk = 1'b1; m_tick = 1'b0; m_busy = 1'b0; m_init = 1'b0;
    end else if (e) begin
      if (m_pos == m_per - 1) begin
        m_tick = 1'b1;
        m_pos  = 0;
        if (m_busy) begin
          m_per  = clamp_div(dec_tab[m_sel]);
          m_busy = 1'b0;
        end
      end else begin
        m_tick = 1'b0;
        m_pos++;
      end
      m_clk = (m_pos < m_per / 2);
    end else begin
      m_tick = 1'b0;
    end
    if (chg) m_busy = 1'b1;
    m_sel = tgt;
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, ".sel_out"}, 32'(sel_out), 32'(m_sel));
    check({pfx, ".clk_out"}, 32'(clk_out), 32'(m_clk));
    check({pfx, ".tick"},    32'(tick),    32'(m_tick));
    check({pfx, ".busy"},    32'(busy),    32'(m_busy));
  endtask

  // Called at a falling edge; applies inputs across one rising edge and checks.
  task automatic cycle(input bit e, input bit u, input bit d);
    en = e; up = u; down = d;
    @(posedge clk);
    model_step(e, u, d);
    @(negedge clk);
    up = 1'b0; down = 1'b0;
    compare_all("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    en = 1'b0; up = 1'b0; down = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_now");
    @(negedge clk);
    compare_all("rst_hold");
    rst = 1'b0;
  endtask

  task automatic run_to_pos(input int k);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!m_init && m_pos == k) found = 1'b1;
      else cycle(1'b1, 1'b0, 1'b0);
    end
    check("run_to_pos", 32'(found), 32'd1);
  endtask

  task automatic step_up_n(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Plain run at sel 0: period 20.
    run(45);

    // Step up mid-period.
    run_to_pos(7);
    cycle(1'b1, 1'b1, 1'b0);
    run(40);

    // Back to sel 0, then collide a step with the boundary.
    cycle(1'b1, 1'b0, 1'b1);
    run(40);
    run_to_pos(19);
    cycle(1'b1, 1'b1, 1'b0);
    run(50);

    // Climb to the top select and try to go past it.
    step_up_n(5);
    run(30);
    step_up_n(1);
    run(10);
    cycle(1'b1, 1'b1, 1'b0);
    run(30);

    // Frozen counter with a pending step.
    run_to_pos(0);
    run(1);
    for (int i = 0; i < 30; i++) cycle(1'b0, (i == 10) ? 1'b0 : 1'b0, (i == 10));
    run(40);

    // Simultaneous up and down.
    cycle(1'b1, 1'b1, 1'b1);
    run(5);

    // Return to period 20 and reset mid-period.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1);
    run(60);
    run_to_pos(12);
    do_reset();
    run(25);

    // Step during INIT.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    run(40);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      int r;
      bit e;
      e = ($urandom_range(0, 9) != 0);
      r = int'($urandom_range(0, 39));
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(e, (r == 0) || (r == 2), (r == 1) || (r == 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
